// File: rtl/regfile_mp_sb.sv
// ----------------------------------------------------------------------------
// regfile_mp_sb
//   Multi-port register file with a load scoreboard.
//   - NUM_RD combinational read ports (0-cycle latency).
//   - Write port A (ALU/EX result) and write port B (load writeback). When both
//     target the same register in one cycle, port A's data is kept.
//   - Per-register busy bit: set by mark_en (load issued), cleared by wb_en.
//     Set wins over clear on the same register in the same cycle.
//   - pend_cnt is the registered popcount of the busy bits; busy_any = pend_cnt != 0.
//   - ZERO_REG=1 makes register 0 read as zero, ignore writes and never be busy.
//
// Optional feature (compile-time macro REGFILE_BYPASS_EN):
//   Defined   : same-cycle write-to-read forwarding (port A over port B); a port B
//               hit also reports rd_busy=0 for that read in that cycle.
//   Undefined : reads return stored contents; rd_busy is the raw busy bit.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   rd_addr    NUM_RD read addresses, port i at [i*AW +: AW]
//   rd_data    NUM_RD read data, port i at [i*DW +: DW]
//   rd_busy    per read port: addressed register has a load outstanding
//   wa_*       write port A (enable, address, data)
//   wb_*       write port B (enable, address, data); wb_en also clears busy
//   mark_*     set busy on mark_addr
//   pend_cnt   number of busy registers
//   busy_any   at least one register busy
// ----------------------------------------------------------------------------
module regfile_mp_sb #(
   parameter int DW       = 32,
   parameter int AW       = 5,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_RD*AW-1:0] rd_addr,
   output logic [NUM_RD*DW-1:0] rd_data,
   output logic [NUM_RD-1:0]    rd_busy,
   input  logic                 wa_en,
   input  logic [AW-1:0]        wa_addr,
   input  logic [DW-1:0]        wa_data,
   input  logic                 wb_en,
   input  logic [AW-1:0]        wb_addr,
   input  logic [DW-1:0]        wb_data,
   input  logic                 mark_en,
   input  logic [AW-1:0]        mark_addr,
   output logic [AW:0]          pend_cnt,
   output logic                 busy_any
);

   localparam int DEPTH = 2 ** AW;

   // True when the address is the hard-wired zero register.
   function automatic logic is_zero(input logic [AW-1:0] addr);
      return (ZERO_REG != 0) && (addr == '0);
   endfunction

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] mem_d [DEPTH];
   logic [DEPTH-1:0] busy_q, busy_d;
   logic [AW:0]      pend_cnt_q, pend_cnt_d;

   logic wa_we, wb_we, mark_we;

   // Effective enables: writes and marks to the zero register are dropped.
   assign wa_we   = wa_en   && !is_zero(wa_addr);
   assign wb_we   = wb_en   && !is_zero(wb_addr);
   assign mark_we = mark_en && !is_zero(mark_addr);

   // Next-state for storage and scoreboard.
   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned, which would infer a latch.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
      end
      // Port B first so that port A overrides it on an address collision.
      if (wb_we) mem_d[wb_addr] = wb_data;
      if (wa_we) mem_d[wa_addr] = wa_data;

      busy_d = busy_q;
      // Clear before set so that a mark on the same register wins.
      if (wb_en)   busy_d[wb_addr]   = 1'b0;
      if (mark_we) busy_d[mark_addr] = 1'b1;

      pend_cnt_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
         pend_cnt_d = pend_cnt_d + (AW+1)'(busy_d[i]);
      end
   end

   // NOTE: the register array is reset together with the control state because
   // reads must return zero from reset onward; this costs a reset on every bit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         busy_q     <= '0;
         pend_cnt_q <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every flop
         // samples the pre-edge value regardless of statement order.
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
         busy_q     <= busy_d;
         pend_cnt_q <= pend_cnt_d;
      end
   end

   // Read ports.
   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         logic [AW-1:0] ra;
         logic [DW-1:0] rdat;
         logic          rbsy;
         ra   = rd_addr[i*AW +: AW];
         rdat = mem_q[ra];
         rbsy = busy_q[ra];
`ifdef REGFILE_BYPASS_EN
         // wa_we/wb_we already exclude the zero register.
         if (wa_we && (wa_addr == ra)) begin
            rdat = wa_data;
         end else if (wb_we && (wb_addr == ra)) begin
            rdat = wb_data;
            rbsy = 1'b0;
         end
`endif
         // Reset is also applied combinationally so a forwarded value cannot
         // leak out while reset is held.
         if (is_zero(ra) || !reset) begin
            rdat = '0;
            rbsy = 1'b0;
         end
         rd_data[i*DW +: DW] = rdat;
         rd_busy[i]          = rbsy;
      end
   end

   assign pend_cnt = pend_cnt_q;
   assign busy_any = (pend_cnt_q != '0);

endmodule

// File: tb/tb_regfile_mp_sb.sv
// ----------------------------------------------------------------------------
// tb_regfile_mp_sb
//   Self-checking bench for regfile_mp_sb (DW=32, AW=5, NUM_RD=4, ZERO_REG=1).
//   Directed reset/collision/zero-register/scoreboard/bypass/multi-port
//   sequences, a constant vector table, then randomized traffic compared
//   against a reference model (register array + set of busy registers).
// ----------------------------------------------------------------------------
module tb_regfile_mp_sb;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic [NR*AW-1:0]  rd_addr;
   logic [NR*DW-1:0]  rd_data;
   logic [NR-1:0]     rd_busy;
   logic              wa_en;
   logic [AW-1:0]     wa_addr;
   logic [DW-1:0]     wa_data;
   logic              wb_en;
   logic [AW-1:0]     wb_addr;
   logic [DW-1:0]     wb_data;
   logic              mark_en;
   logic [AW-1:0]     mark_addr;
   logic [AW:0]       pend_cnt;
   logic              busy_any;

   regfile_mp_sb #(.DW(DW), .AW(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
      .clk       (clk),
      .reset     (reset),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .rd_busy   (rd_busy),
      .wa_en     (wa_en),
      .wa_addr   (wa_addr),
      .wa_data   (wa_data),
      .wb_en     (wb_en),
      .wb_addr   (wb_addr),
      .wb_data   (wb_data),
      .mark_en   (mark_en),
      .mark_addr (mark_addr),
      .pend_cnt  (pend_cnt),
      .busy_any  (busy_any)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: register contents plus the set of busy register numbers.
   logic [DW-1:0] m_regs [32];
   bit            m_busy [int];

   typedef struct packed {
      logic           wa_en;
      logic [4:0]     wa_addr;
      logic [31:0]    wa_data;
      logic           wb_en;
      logic [4:0]     wb_addr;
      logic [31:0]    wb_data;
      logic           mark_en;
      logic [4:0]     mark_addr;
      logic [19:0]    ra;   // {p3,p2,p1,p0}
      logic [127:0]   er;   // expected read data before the edge, {p3,p2,p1,p0}
      logic [3:0]     eb;   // expected rd_busy before the edge
      logic [5:0]     ep;   // expected pend_cnt after the edge
   } vec_t;

   vec_t tbl [6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] rdp(input int i);
      return rd_data[i*DW +: DW];
   endfunction

   function automatic logic [AW-1:0] rap(input int i);
      return rd_addr[i*AW +: AW];
   endfunction

   task automatic idle();
      wa_en = 0; wa_addr = '0; wa_data = '0;
      wb_en = 0; wb_addr = '0; wb_data = '0;
      mark_en = 0; mark_addr = '0;
   endtask

   task automatic drive(input logic wae, input logic [4:0] waa, input logic [31:0] wad,
                        input logic wbe, input logic [4:0] wba, input logic [31:0] wbd,
                        input logic me, input logic [4:0] ma);
      wa_en = wae; wa_addr = waa; wa_data = wad;
      wb_en = wbe; wb_addr = wba; wb_data = wbd;
      mark_en = me; mark_addr = ma;
   endtask

   task automatic set_rd_all(input logic [4:0] a);
      rd_addr = {4{a}};
   endtask

   function automatic logic [DW-1:0] m_rd(input logic [AW-1:0] a);
      if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
      if (wa_en && wa_addr == a) return wa_data;
      if (wb_en && wb_addr == a) return wb_data;
`endif
      return m_regs[a];
   endfunction

   function automatic logic m_bz(input logic [AW-1:0] a);
      if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
      if (!(wa_en && wa_addr == a) && wb_en && wb_addr == a) return 1'b0;
`endif
      return m_busy.exists(int'(a));
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_busy.delete();
   endtask

   // Apply the architectural rules of one clock edge to the model.
   task automatic m_edge();
      if (wb_en && wb_addr != 0) m_regs[wb_addr] = wb_data;
      if (wa_en && wa_addr != 0) m_regs[wa_addr] = wa_data;
      if (wb_en) m_busy.delete(int'(wb_addr));
      if (mark_en && mark_addr != 0) m_busy[int'(mark_addr)] = 1'b1;
   endtask

   // One clock edge; returns at negedge + 1.
   task automatic edge_step();
      @(posedge clk);
      m_edge();
      @(negedge clk);
      #1;
   endtask

   task automatic check_comb(input string tag);
      for (int i = 0; i < NR; i++) begin
         check($sformatf("%s rd_data[%0d]", tag, i), 64'(rdp(i)), 64'(m_rd(rap(i))));
         check($sformatf("%s rd_busy[%0d]", tag, i), 64'(rd_busy[i]), 64'(m_bz(rap(i))));
      end
   endtask

   task automatic check_reg(input string tag);
      check({tag, " pend_cnt"}, 64'(pend_cnt), 64'(m_busy.num()));
      check({tag, " busy_any"}, 64'(busy_any), 64'(m_busy.num() != 0));
   endtask

   function automatic logic [AW-1:0] rnd_addr();
      if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, 31));
      return AW'($urandom_range(0, 7));
   endfunction

   initial begin
      // Vector table (starts from the all-zero post-reset state).
      tbl[0] = '{1'b1, 5'd1, 32'h11111111, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                 {5'd5, 5'd4, 5'd3, 5'd2}, {32'h0, 32'h0, 32'h0, 32'h0}, 4'b0000, 6'd0};
      tbl[1] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 32'h22222222, 1'b1, 5'd4,
                 {5'd7, 5'd6, 5'd3, 5'd1}, {32'h0, 32'h0, 32'h0, 32'h11111111}, 4'b0000, 6'd1};
      tbl[2] = '{1'b1, 5'd3, 32'h33, 1'b1, 5'd6, 32'h66, 1'b0, 5'd0,
                 {5'd0, 5'd4, 5'd2, 5'd1}, {32'h0, 32'h0, 32'h22222222, 32'h11111111}, 4'b0100, 6'd1};
      tbl[3] = '{1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'h0, 1'b1, 5'd10,
                 {5'd0, 5'd5, 5'd6, 5'd3}, {32'h0, 32'h0, 32'h66, 32'h33}, 4'b0000, 6'd2};
      tbl[4] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h4B, 1'b0, 5'd0,
                 {5'd1, 5'd6, 5'd3, 5'd10}, {32'h11111111, 32'h66, 32'h33, 32'h0}, 4'b0001, 6'd1};
      tbl[5] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                 {5'd0, 5'd2, 5'd10, 5'd4}, {32'h0, 32'h22222222, 32'h0, 32'h4B}, 4'b0010, 6'd1};

      // ---- Reset state ----
      reset = 1'b0;
      idle();
      rd_addr = '0;
      m_reset();
      @(negedge clk);
      @(negedge clk);
      #1;
      check("reset pend_cnt", 64'(pend_cnt), 64'd0);
      check("reset busy_any", 64'(busy_any), 64'd0);
      reset = 1'b1;

      // ---- T1: async reset mid-cycle ----
      drive(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 1, 5'd5);
      set_rd_all(5'd5);
      edge_step();
      idle();
      #1;
      check("T1 r5 written", 64'(rdp(0)), 64'hDEADBEEF);
      check("T1 pend before reset", 64'(pend_cnt), 64'd1);
      reset = 1'b0;
      #1;
      m_reset();
      check("T1 r5 under reset", 64'(rdp(0)), 64'd0);
      check("T1 busy under reset", 64'(rd_busy[0]), 64'd0);
      check("T1 pend under reset", 64'(pend_cnt), 64'd0);
      check("T1 busy_any under reset", 64'(busy_any), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("T1 r5 after reset", 64'(rdp(0)), 64'd0);

      // ---- Vector table ----
      for (int v = 0; v < 6; v++) begin
         drive(tbl[v].wa_en, tbl[v].wa_addr, tbl[v].wa_data,
               tbl[v].wb_en, tbl[v].wb_addr, tbl[v].wb_data,
               tbl[v].mark_en, tbl[v].mark_addr);
         rd_addr = tbl[v].ra;
         #1;
         for (int i = 0; i < NR; i++) begin
            check($sformatf("vec%0d rd_data[%0d]", v, i), 64'(rdp(i)), 64'(tbl[v].er[i*32 +: 32]));
            check($sformatf("vec%0d rd_busy[%0d]", v, i), 64'(rd_busy[i]), 64'(tbl[v].eb[i]));
         end
         edge_step();
         check($sformatf("vec%0d pend_cnt", v), 64'(pend_cnt), 64'(tbl[v].ep));
      end
      idle();
      drive(0, 0, 0, 1, 5'd10, 32'h0, 0, 0);  // clear r10 so the scoreboard is empty
      edge_step();
      idle();
      #1;
      check("clear r10 pend", 64'(pend_cnt), 64'd0);

      // ---- T2: dual write collision ----
      drive(1, 5'd3, 32'h11, 1, 5'd3, 32'h22, 0, 0);
      edge_step();
      idle();
      set_rd_all(5'd3);
      #1;
      check("T2 r3 port A wins", 64'(rdp(0)), 64'h11);

      // ---- T3: zero register ----
      drive(1, 5'd0, 32'hFFFF, 0, 0, 0, 1, 5'd0);
      set_rd_all(5'd0);
      #1;
      check("T3 r0 same cycle", 64'(rdp(0)), 64'd0);
      check("T3 r0 busy same cycle", 64'(rd_busy[0]), 64'd0);
      edge_step();
      idle();
      #1;
      check("T3 r0 data", 64'(rdp(1)), 64'd0);
      check("T3 r0 busy", 64'(rd_busy[1]), 64'd0);
      check("T3 pend_cnt", 64'(pend_cnt), 64'd0);

      // ---- T4: scoreboard ----
      drive(0, 0, 0, 0, 0, 0, 1, 5'd7);
      set_rd_all(5'd7);
      edge_step();
      idle();
      #1;
      check("T4 mark busy", 64'(rd_busy[0]), 64'd1);
      check("T4 mark pend", 64'(pend_cnt), 64'd1);
      drive(0, 0, 0, 1, 5'd7, 32'h55, 1, 5'd7);
      edge_step();
      idle();
      #1;
      check("T4 set wins busy", 64'(rd_busy[0]), 64'd1);
      check("T4 set wins pend", 64'(pend_cnt), 64'd1);
      check("T4 r7 data 55", 64'(rdp(0)), 64'h55);
      drive(0, 0, 0, 1, 5'd7, 32'h66, 0, 0);
      edge_step();
      idle();
      #1;
      check("T4 clear busy", 64'(rd_busy[0]), 64'd0);
      check("T4 clear pend", 64'(pend_cnt), 64'd0);
      check("T4 r7 data 66", 64'(rdp(0)), 64'h66);

      // ---- T5: same-cycle write/read ----
      drive(1, 5'd9, 32'h12, 0, 0, 0, 1, 5'd9);
      edge_step();
      idle();
      drive(0, 0, 0, 1, 5'd9, 32'hAB, 0, 0);
      set_rd_all(5'd9);
      #1;
`ifdef REGFILE_BYPASS_EN
      check("T5 same-cycle data", 64'(rdp(0)), 64'hAB);
      check("T5 same-cycle busy", 64'(rd_busy[0]), 64'd0);
`else
      check("T5 same-cycle data", 64'(rdp(0)), 64'h12);
      check("T5 same-cycle busy", 64'(rd_busy[0]), 64'd1);
`endif
      edge_step();
      idle();
      #1;
      check("T5 next-cycle data", 64'(rdp(0)), 64'hAB);
      check("T5 next-cycle busy", 64'(rd_busy[0]), 64'd0);

      // ---- T6: four read ports ----
      drive(1, 5'd1, 32'd1, 1, 5'd2, 32'd2, 0, 0);
      edge_step();
      idle();
      rd_addr = {5'd0, 5'd1, 5'd2, 5'd1};
      #1;
      check("T6 port0", 64'(rdp(0)), 64'd1);
      check("T6 port1", 64'(rdp(1)), 64'd2);
      check("T6 port2", 64'(rdp(2)), 64'd1);
      check("T6 port3", 64'(rdp(3)), 64'd0);

      // ---- Randomized traffic against the model ----
      check_comb("pre-random");
      check_reg("pre-random");
      for (int c = 0; c < 400; c++) begin
         drive(1'($urandom_range(0, 1)), rnd_addr(), $urandom(),
               1'($urandom_range(0, 1)), rnd_addr(), $urandom(),
               1'($urandom_range(0, 1)), rnd_addr());
         for (int i = 0; i < NR; i++) rd_addr[i*AW +: AW] = rnd_addr();
         #1;
         check_comb($sformatf("rnd%0d", c));
         edge_step();
         check_reg($sformatf("rnd%0d", c));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
